// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage load/store engine over a req/gnt/rvalid data bus
// Stalls the pipeline for the duration of an aligned access; misaligned accesses fault without bus activity.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MEM_W_En_M,
  input  logic        MEM_R_En_M,
  input  logic [2:0]  MEM_Control_M,
  input  logic [31:0] ALU_Out_M,
  input  logic [31:0] SrcB_Reg_M,
  output logic        DM_REQ,
  output logic        DM_WE,
  output logic [31:0] DM_ADDR,
  output logic [3:0]  DM_BE,
  output logic [31:0] DM_WDATA,
  input  logic        DM_GNT,
  input  logic        DM_RVALID,
  input  logic [31:0] DM_RDATA,
  output logic [31:0] Load_Data_M,
  output logic        MEM_Stall_M,
  output logic        MEM_Fault_M
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   ld_q, ld_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [1:0]    off_q, off_d;

  logic        is_byte, is_half, aligned, pending, timeout;
  logic [1:0]  off;
  logic [3:0]  be_next;
  logic [31:0] wdata_next, rshift, ld_ext;

  // Codes x00 are byte, x01 half; everything else behaves as a word.
  assign is_byte = (MEM_Control_M[1:0] == 2'b00);
  assign is_half = (MEM_Control_M[1:0] == 2'b01);
  assign off     = ALU_Out_M[1:0];
  assign aligned = is_byte | (is_half & ~off[0]) | (~is_byte & ~is_half & (off == 2'b00));
  assign pending = (MEM_W_En_M | MEM_R_En_M) & (state_q == S_IDLE);
  assign timeout = (cnt_q >= LAST);

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = SrcB_Reg_M;
    if (is_byte) begin
      be_next    = 4'b0001 << off;
      wdata_next = {4{SrcB_Reg_M[7:0]}};
    end else if (is_half) begin
      be_next    = 4'b0011 << off;
      wdata_next = {2{SrcB_Reg_M[15:0]}};
    end
  end

  // Lane selection uses the offset and funct3 latched at request time.
  assign rshift = DM_RDATA >> {off_q, 3'b000};

  always_comb begin
    case (op_q)
      3'b000:  ld_ext = {{24{rshift[7]}}, rshift[7:0]};
      3'b100:  ld_ext = {24'd0, rshift[7:0]};
      3'b001:  ld_ext = {{16{rshift[15]}}, rshift[15:0]};
      3'b101:  ld_ext = {16'd0, rshift[15:0]};
      default: ld_ext = DM_RDATA;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;
    fault_d = 1'b0;
    cnt_d   = cnt_q;
    op_d    = op_q;
    off_d   = off_q;
    case (state_q)
      S_IDLE: begin
        if (pending) begin
          if (aligned) begin
            state_d = S_REQ;
            req_d   = 1'b1;
            we_d    = MEM_W_En_M;
            addr_d  = {ALU_Out_M[31:2], 2'b00};
            be_d    = be_next;
            wdata_d = wdata_next;
            op_d    = MEM_Control_M;
            off_d   = off;
            cnt_d   = '0;
          end else begin
            fault_d = 1'b1;
            ld_d    = '0;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (DM_GNT) begin
          req_d   = 1'b0;
          state_d = we_q ? S_DONE : S_RESP;
        end else if (timeout) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          fault_d = 1'b1;
          ld_d    = '0;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (DM_RVALID) begin
          ld_d    = ld_ext;
          state_d = S_DONE;
        end else if (timeout) begin
          state_d = S_DONE;
          fault_d = 1'b1;
          ld_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      off_q   <= off_d;
    end
  end

  assign DM_REQ      = req_q;
  assign DM_WE       = we_q;
  assign DM_ADDR     = addr_q;
  assign DM_BE       = be_q;
  assign DM_WDATA    = wdata_q;
  assign Load_Data_M = ld_q;
  assign MEM_Fault_M = fault_q;
  // Gated by reset so a held enable cannot stall the pipeline while the unit is in reset.
  assign MEM_Stall_M = RST_N & ((pending & aligned) | (state_q == S_REQ) | (state_q == S_RESP));

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed vector bench for mem_access_unit
// The bench plays the data memory: grants after a per-vector delay and returns read data after another.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        MEM_W_En_M = 1'b0;
  logic        MEM_R_En_M = 1'b0;
  logic [2:0]  MEM_Control_M = 3'b000;
  logic [31:0] ALU_Out_M = '0;
  logic [31:0] SrcB_Reg_M = '0;
  logic        DM_REQ, DM_WE;
  logic [31:0] DM_ADDR, DM_WDATA;
  logic [3:0]  DM_BE;
  logic        DM_GNT = 1'b0;
  logic        DM_RVALID = 1'b0;
  logic [31:0] DM_RDATA = '0;
  logic [31:0] Load_Data_M;
  logic        MEM_Stall_M, MEM_Fault_M;

  int checks = 0;
  int failures = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .MEM_W_En_M(MEM_W_En_M), .MEM_R_En_M(MEM_R_En_M),
    .MEM_Control_M(MEM_Control_M), .ALU_Out_M(ALU_Out_M), .SrcB_Reg_M(SrcB_Reg_M),
    .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_BE(DM_BE), .DM_WDATA(DM_WDATA),
    .DM_GNT(DM_GNT), .DM_RVALID(DM_RVALID), .DM_RDATA(DM_RDATA),
    .Load_Data_M(Load_Data_M), .MEM_Stall_M(MEM_Stall_M), .MEM_Fault_M(MEM_Fault_M)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic        re;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          gnt_after;
    int          rv_after;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_stall;
    logic        exp_fault;
    logic [31:0] exp_ld;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic we, logic re, logic [2:0] ctrl, logic [31:0] addr,
                              logic [31:0] sdata, logic [31:0] rdata, int g, int r,
                              logic ereq, logic [31:0] eaddr, logic [3:0] ebe,
                              logic [31:0] ewd, int estall, logic efault, logic [31:0] eld);
    vec_t v;
    v.we = we; v.re = re; v.ctrl = ctrl; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.gnt_after = g; v.rv_after = r; v.exp_req = ereq; v.exp_addr = eaddr; v.exp_be = ebe;
    v.exp_wdata = ewd; v.exp_stall = estall; v.exp_fault = efault; v.exp_ld = eld;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] sdata);
    MEM_W_En_M = we; MEM_R_En_M = re; MEM_Control_M = ctrl;
    ALU_Out_M = addr; SrcB_Reg_M = sdata;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int stall_cnt, req_cycles, rv_wait;
    logic gnt_given, finished, fault_now;
    logic [31:0] cap_addr, cap_wdata, ld_done;
    logic [3:0] cap_be;
    logic cap_we;
    stall_cnt = 0; req_cycles = 0; rv_wait = 0; gnt_given = 0; finished = 0; fault_now = 0;
    cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 0; ld_done = '0;
    @(posedge CLK); #1;
    drive(v.we, v.re, v.ctrl, v.addr, v.sdata);
    for (int c = 0; c < 64; c++) begin
      @(negedge CLK);
      DM_GNT = 0; DM_RVALID = 0;
      if (!MEM_Stall_M) begin
        fault_now = MEM_Fault_M; ld_done = Load_Data_M; finished = 1;
        break;
      end
      stall_cnt++;
      if (DM_REQ) begin
        req_cycles++;
        if (req_cycles == v.gnt_after + 1) begin
          DM_GNT = 1; gnt_given = 1;
          cap_addr = DM_ADDR; cap_be = DM_BE; cap_wdata = DM_WDATA; cap_we = DM_WE;
        end
      end else if (gnt_given && !v.we) begin
        rv_wait++;
        if (rv_wait == v.rv_after + 1) begin
          DM_RVALID = 1; DM_RDATA = v.rdata;
        end
      end
    end
    @(posedge CLK); #1;
    drive(0, 0, 3'b000, '0, '0);
    @(negedge CLK);
    chk($sformatf("v%0d_finished", idx), {31'd0, finished}, 32'd1);
    chk($sformatf("v%0d_stall_cycles", idx), stall_cnt, v.exp_stall);
    chk($sformatf("v%0d_req_seen", idx), {31'd0, req_cycles > 0}, {31'd0, v.exp_req});
    chk($sformatf("v%0d_fault_at_release", idx), {31'd0, fault_now}, 32'd0);
    chk($sformatf("v%0d_fault_next", idx), {31'd0, MEM_Fault_M}, {31'd0, v.exp_fault});
    chk($sformatf("v%0d_load_data", idx), Load_Data_M, v.exp_ld);
    if (v.exp_req) begin
      chk($sformatf("v%0d_addr", idx), cap_addr, v.exp_addr);
      chk($sformatf("v%0d_be", idx), {28'd0, cap_be}, {28'd0, v.exp_be});
      chk($sformatf("v%0d_wdata", idx), cap_wdata, v.exp_wdata);
      chk($sformatf("v%0d_we", idx), {31'd0, cap_we}, {31'd0, v.we});
      if (v.re) chk($sformatf("v%0d_load_at_done", idx), ld_done, v.exp_ld);
    end
  endtask

  task automatic timeout_seq(input string name, input logic give_gnt);
    int stall_cnt;
    logic gnt_done, finished, fault_done, req_done;
    logic [31:0] ld_done;
    stall_cnt = 0; gnt_done = 0; finished = 0; fault_done = 0; req_done = 1; ld_done = 'x;
    @(posedge CLK); #1;
    drive(0, 1, 3'b010, 32'h0000_0200, '0);
    for (int c = 0; c < 64; c++) begin
      @(negedge CLK);
      DM_GNT = 0;
      if (!MEM_Stall_M) begin
        fault_done = MEM_Fault_M; req_done = DM_REQ; ld_done = Load_Data_M; finished = 1;
        break;
      end
      stall_cnt++;
      if (give_gnt && DM_REQ && !gnt_done) begin
        DM_GNT = 1; gnt_done = 1;
      end
    end
    @(posedge CLK); #1;
    drive(0, 0, 3'b000, '0, '0);
    chk({name, "_finished"}, {31'd0, finished}, 32'd1);
    chk({name, "_stall_cycles"}, stall_cnt, 17);
    chk({name, "_fault"}, {31'd0, fault_done}, 32'd1);
    chk({name, "_req_at_done"}, {31'd0, req_done}, 32'd0);
    chk({name, "_load_zero"}, ld_done, 32'd0);
    // A stray read response after completion must be ignored.
    @(negedge CLK);
    DM_RVALID = 1; DM_RDATA = 32'hFFFF_FFFF;
    @(negedge CLK);
    DM_RVALID = 0;
    chk({name, "_late_rvalid_ignored"}, Load_Data_M, 32'd0);
    chk({name, "_fault_pulse_ended"}, {31'd0, MEM_Fault_M}, 32'd0);
  endtask

  task automatic reset_in_resp();
    logic reached;
    logic gnt_done;
    reached = 0; gnt_done = 0;
    @(posedge CLK); #1;
    drive(0, 1, 3'b010, 32'h0000_0104, '0);
    for (int c = 0; c < 32; c++) begin
      @(negedge CLK);
      DM_GNT = 0;
      if (gnt_done && !DM_REQ && MEM_Stall_M) begin
        reached = 1;
        break;
      end
      if (DM_REQ && !gnt_done) begin
        DM_GNT = 1; gnt_done = 1;
      end
    end
    chk("rst_reached_resp", {31'd0, reached}, 32'd1);
    chk("rst_pre_load_nonzero", Load_Data_M, 32'hCAFE_F00D);
    RST_N = 0;
    #1;
    chk("rst_req", {31'd0, DM_REQ}, 32'd0);
    chk("rst_addr", DM_ADDR, 32'd0);
    chk("rst_be", {28'd0, DM_BE}, 32'd0);
    chk("rst_load", Load_Data_M, 32'd0);
    chk("rst_stall", {31'd0, MEM_Stall_M}, 32'd0);
    chk("rst_fault", {31'd0, MEM_Fault_M}, 32'd0);
    @(posedge CLK); #1;
    drive(0, 0, 3'b000, '0, '0);
    @(negedge CLK);
    RST_N = 1;
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 0,             2, 0, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 4, 0, 32'h0);
    vecs[1]  = mk(1, 0, 3'b000, 32'h103, 32'h123456AB, 0,             0, 0, 1, 32'h100, 4'b1000, 32'hABABABAB, 2, 0, 32'h0);
    vecs[2]  = mk(1, 0, 3'b001, 32'h202, 32'h0000BEEF, 0,             1, 0, 1, 32'h200, 4'b1100, 32'hBEEFBEEF, 3, 0, 32'h0);
    vecs[3]  = mk(0, 1, 3'b000, 32'h102, 0,            32'h00800000,  0, 0, 1, 32'h100, 4'b0100, 32'h0,        3, 0, 32'hFFFFFF80);
    vecs[4]  = mk(0, 1, 3'b100, 32'h102, 0,            32'h00800000,  1, 2, 1, 32'h100, 4'b0100, 32'h0,        6, 0, 32'h00000080);
    vecs[5]  = mk(0, 1, 3'b101, 32'h102, 0,            32'h00800000,  0, 0, 1, 32'h100, 4'b1100, 32'h0,        3, 0, 32'h00000080);
    vecs[6]  = mk(0, 1, 3'b001, 32'h100, 0,            32'h12348001,  0, 1, 1, 32'h100, 4'b0011, 32'h0,        4, 0, 32'hFFFF8001);
    vecs[7]  = mk(0, 1, 3'b010, 32'h104, 0,            32'hCAFEF00D,  0, 0, 1, 32'h104, 4'b1111, 32'h0,        3, 0, 32'hCAFEF00D);
    vecs[8]  = mk(0, 1, 3'b010, 32'h101, 0,            32'h0,         0, 0, 0, 32'h0,   4'b0000, 32'h0,        0, 1, 32'h0);
    vecs[9]  = mk(0, 1, 3'b000, 32'h0FF, 0,            32'h7F000000,  0, 0, 1, 32'h0FC, 4'b1000, 32'h0,        3, 0, 32'h0000007F);
    vecs[10] = mk(1, 0, 3'b010, 32'h102, 32'h11111111, 0,             0, 0, 0, 32'h0,   4'b0000, 32'h0,        0, 1, 32'h0);
    vecs[11] = mk(0, 1, 3'b011, 32'h108, 0,            32'h11223344,  0, 0, 1, 32'h108, 4'b1111, 32'h0,        3, 0, 32'h11223344);
    vecs[12] = mk(1, 0, 3'b001, 32'h301, 32'h2222,     0,             0, 0, 0, 32'h0,   4'b0000, 32'h0,        0, 1, 32'h0);
    vecs[13] = mk(0, 1, 3'b101, 32'h106, 0,            32'hFFFF0000,  0, 0, 1, 32'h104, 4'b1100, 32'h0,        3, 0, 32'h0000FFFF);
    vecs[14] = mk(1, 0, 3'b000, 32'h001, 32'h0000005A, 0,             0, 0, 1, 32'h000, 4'b0010, 32'h5A5A5A5A, 2, 0, 32'h0000FFFF);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_req", {31'd0, DM_REQ}, 32'd0);
    chk("reset_we", {31'd0, DM_WE}, 32'd0);
    chk("reset_addr", DM_ADDR, 32'd0);
    chk("reset_wdata", DM_WDATA, 32'd0);
    chk("reset_load", Load_Data_M, 32'd0);
    chk("reset_stall", {31'd0, MEM_Stall_M}, 32'd0);
    chk("reset_fault", {31'd0, MEM_Fault_M}, 32'd0);
    RST_N = 1;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    timeout_seq("timeout_resp", 1'b1);
    timeout_seq("timeout_req", 1'b0);

    run_vec(7, vecs[7]);
    reset_in_resp();
    run_vec(0, vecs[0]);
    run_vec(3, vecs[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
